// File: rtl/wb_div_initiator_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_div_initiator_if
//  Description : Command/response and Wishbone master bundle for the serial
//                divider initiator.
//  Revision    : 1.0  initial release
// ============================================================================
interface wb_div_initiator_if #(
    parameter int WBW  = 32,
    parameter int XLEN = 32
);
    // local requester side
    logic              req_valid_i;
    logic              req_ready_o;
    logic [XLEN-1:0]   req_dividend_i;
    logic [XLEN-1:0]   req_divisor_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [XLEN-1:0]   rsp_quot_o;
    logic [XLEN-1:0]   rsp_rem_o;
    logic [1:0]        rsp_err_o;
    // Wishbone side
    logic              wbm_cyc_o;
    logic              wbm_stb_o;
    logic              wbm_we_o;
    logic [WBW/8-1:0]  wbm_sel_o;
    logic [WBW-1:0]    wbm_adr_o;
    logic [WBW-1:0]    wbm_dat_o;
    logic              wbm_ack_i;
    logic [WBW-1:0]    wbm_dat_i;
    logic              busy_o;

    // initiator view
    modport master (
        input  req_valid_i, req_dividend_i, req_divisor_i, rsp_ready_i,
               wbm_ack_i, wbm_dat_i,
        output req_ready_o, rsp_valid_o, rsp_quot_o, rsp_rem_o, rsp_err_o,
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o,
               wbm_dat_o, busy_o
    );

    // requester + bus slave view
    modport slave (
        output req_valid_i, req_dividend_i, req_divisor_i, rsp_ready_i,
               wbm_ack_i, wbm_dat_i,
        input  req_ready_o, rsp_valid_o, rsp_quot_o, rsp_rem_o, rsp_err_o,
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o,
               wbm_dat_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_div_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : wb_div_initiator
//  Description : Wishbone initiator that loads the serial divider's operands,
//                starts it, polls FINI, reads quotient/remainder and returns
//                them on a valid/ready response port.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_div_initiator #(
    parameter int              WBW         = 32,
    parameter int              XLEN        = 32,
    parameter logic [WBW-1:0]  BASE_ADDR   = WBW'(32'h3000_0000),
    parameter int              ACK_TIMEOUT = 16,
    parameter int              POLL_LIMIT  = 64,
    parameter int              POLL_GAP    = 2     // must be >= 1
) (
    input  wire logic           clk_i,
    input  wire logic           reset_ni,
    wb_div_initiator_if.master  bus
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WR_DVD   = 4'd1;
    localparam logic [3:0] S_WR_DVS   = 4'd2;
    localparam logic [3:0] S_WR_START = 4'd3;
    localparam logic [3:0] S_POLL     = 4'd4;
    localparam logic [3:0] S_GAP      = 4'd5;
    localparam logic [3:0] S_RD_Q     = 4'd6;
    localparam logic [3:0] S_RD_R     = 4'd7;
    localparam logic [3:0] S_RESP     = 4'd8;

    localparam logic [WBW-1:0] OFF_DVD   = WBW'(32'h00);
    localparam logic [WBW-1:0] OFF_DVS   = WBW'(32'h04);
    localparam logic [WBW-1:0] OFF_QUOT  = WBW'(32'h08);
    localparam logic [WBW-1:0] OFF_REM   = WBW'(32'h0C);
    localparam logic [WBW-1:0] OFF_FINI  = WBW'(32'h14);
    localparam logic [WBW-1:0] OFF_START = WBW'(32'h18);

    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    localparam int PC_W = $clog2(POLL_LIMIT + 1);
    localparam int GP_W = $clog2(POLL_GAP + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(POLL_LIMIT - 1);
    localparam logic [GP_W-1:0] GP_LAST = GP_W'(POLL_GAP - 1);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ACK_TO  = 2'd1;
    localparam logic [1:0] ERR_POLL    = 2'd2;
    localparam logic [1:0] ERR_DIVISOR = 2'd3;

    logic [3:0]       state;
    logic [XLEN-1:0]  dividend;
    logic [XLEN-1:0]  divisor;
    logic [XLEN-1:0]  quot;
    logic [XLEN-1:0]  rem;
    logic [1:0]       err;
    logic             stb;          // cyc and stb always move together
    logic [TO_W-1:0]  to_cnt;
    logic [PC_W-1:0]  poll_cnt;
    logic [GP_W-1:0]  gap_cnt;

    logic [WBW-1:0]   cur_adr;
    logic [WBW-1:0]   cur_dat;
    logic             cur_we;

    // Address / direction / write data of the transfer owned by the current state.
    always_comb begin
        cur_adr = '0;
        cur_dat = '0;
        cur_we  = 1'b0;
        case (state)
            S_WR_DVD: begin
                cur_adr = BASE_ADDR + OFF_DVD;
                cur_dat = WBW'(dividend);
                cur_we  = 1'b1;
            end
            S_WR_DVS: begin
                cur_adr = BASE_ADDR + OFF_DVS;
                cur_dat = WBW'(divisor);
                cur_we  = 1'b1;
            end
            S_WR_START: begin
                cur_adr = BASE_ADDR + OFF_START;
                cur_we  = 1'b1;
            end
            S_POLL:  cur_adr = BASE_ADDR + OFF_FINI;
            S_RD_Q:  cur_adr = BASE_ADDR + OFF_QUOT;
            S_RD_R:  cur_adr = BASE_ADDR + OFF_REM;
            default: cur_adr = '0;
        endcase
    end

    // Sequencer: one registered strobe per bus state, with an idle cycle on
    // entry so consecutive transfers are never back-to-back. The poll gap
    // raises the strobe itself so FINI reads are exactly POLL_GAP cycles apart.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state    <= S_IDLE;
            dividend <= '0;
            divisor  <= '0;
            quot     <= '0;
            rem      <= '0;
            err      <= ERR_OK;
            stb      <= 1'b0;
            to_cnt   <= '0;
            poll_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid_i) begin
                        dividend <= bus.req_dividend_i;
                        divisor  <= bus.req_divisor_i;
                        quot     <= '0;
                        rem      <= '0;
                        poll_cnt <= '0;
                        // the divider never finishes for divisor 0 or 1
                        if (bus.req_divisor_i[XLEN-1:1] == '0) begin
                            err   <= ERR_DIVISOR;
                            state <= S_RESP;
                        end else begin
                            err   <= ERR_OK;
                            state <= S_WR_DVD;
                        end
                    end
                end

                S_WR_DVD, S_WR_DVS, S_WR_START, S_POLL, S_RD_Q, S_RD_R: begin
                    if (!stb) begin
                        stb    <= 1'b1;
                        to_cnt <= '0;
                    end else if (bus.wbm_ack_i) begin
                        stb <= 1'b0;
                        case (state)
                            S_WR_DVD:   state <= S_WR_DVS;
                            S_WR_DVS:   state <= S_WR_START;
                            S_WR_START: state <= S_POLL;
                            S_POLL: begin
                                if (bus.wbm_dat_i[0]) begin
                                    state <= S_RD_Q;
                                end else if (poll_cnt == PC_LAST) begin
                                    err   <= ERR_POLL;
                                    state <= S_RESP;
                                end else begin
                                    poll_cnt <= poll_cnt + 1'b1;
                                    gap_cnt  <= '0;
                                    state    <= S_GAP;
                                end
                            end
                            S_RD_Q: begin
                                quot  <= bus.wbm_dat_i[XLEN-1:0];
                                state <= S_RD_R;
                            end
                            default: begin
                                rem   <= bus.wbm_dat_i[XLEN-1:0];
                                state <= S_RESP;
                            end
                        endcase
                    end else if (to_cnt == TO_LAST) begin
                        stb   <= 1'b0;
                        err   <= ERR_ACK_TO;
                        state <= S_RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                S_GAP: begin
                    if (gap_cnt == GP_LAST) begin
                        stb    <= 1'b1;
                        to_cnt <= '0;
                        state  <= S_POLL;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    if (bus.rsp_ready_i) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    stb   <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Bus outputs are zero whenever no transfer is in flight.
    assign bus.wbm_cyc_o = stb;
    assign bus.wbm_stb_o = stb;
    assign bus.wbm_we_o  = stb & cur_we;
    assign bus.wbm_sel_o = {(WBW/8){stb}};
    assign bus.wbm_adr_o = stb ? cur_adr : '0;
    assign bus.wbm_dat_o = stb ? cur_dat : '0;

    assign bus.req_ready_o = (state == S_IDLE);
    assign bus.rsp_valid_o = (state == S_RESP);
    assign bus.rsp_quot_o  = quot;
    assign bus.rsp_rem_o   = rem;
    assign bus.rsp_err_o   = err;
    assign bus.busy_o      = (state != S_IDLE);

endmodule
`default_nettype wire
